// File: rtl/btb_predictor_pkg.sv
// Shared constants for the BTB predictor: counter encodings and PC width.
// Optional build macro used by the top: BTB_UPD_BYPASS_EN.
`ifndef RV32_PC_WIDTH
`define RV32_PC_WIDTH 32
`endif

package btb_predictor_pkg;

    localparam int unsigned PC_W = `RV32_PC_WIDTH;

    localparam logic [1:0] BTB_CNT_SN    = 2'b00;
    localparam logic [1:0] BTB_CNT_WN    = 2'b01;
    localparam logic [1:0] BTB_CNT_WT    = 2'b10;
    localparam logic [1:0] BTB_CNT_ST    = 2'b11;
    localparam logic [1:0] BTB_CNT_RESET = BTB_CNT_WN;
    localparam logic [1:0] BTB_CNT_ALLOC = BTB_CNT_WT;

endpackage

// File: rtl/btb_predictor_sat_cnt2.sv
// 2-bit saturating direction counter next-value (combinational).
module btb_predictor_sat_cnt2
    import btb_predictor_pkg::*;
(
    input  logic [1:0] i_cnt,
    input  logic       i_taken,
    output logic [1:0] o_cnt
);

    always_comb begin
        o_cnt = i_cnt;
        if (i_taken && (i_cnt != BTB_CNT_ST)) begin
            o_cnt = i_cnt + 2'd1;
        end else if (!i_taken && (i_cnt != BTB_CNT_SN)) begin
            o_cnt = i_cnt - 2'd1;
        end
    end

endmodule

// File: rtl/btb_predictor.sv
// Direct-mapped BTB with 2-bit direction counters for a two-wide fetch group.
// Define BTB_UPD_BYPASS_EN to forward a same-cycle update into the lookup.
`ifndef RV32_PC_WIDTH
`define RV32_PC_WIDTH 32
`endif

module btb_predictor
    import btb_predictor_pkg::*;
#(
    parameter int unsigned ENTRY_NUM = 16
) (
    input  logic                      clk,
    input  logic                      rst_n,
    input  logic [`RV32_PC_WIDTH-1:0] i_pc,
    output logic                      o_pred_jmp,
    output logic [`RV32_PC_WIDTH-1:0] o_pred_jmpaddr,
    output logic                      o_pred_slot,
    input  logic                      i_upd_valid,
    input  logic [`RV32_PC_WIDTH-1:0] i_upd_pc,
    input  logic                      i_upd_taken,
    input  logic [`RV32_PC_WIDTH-1:0] i_upd_target
);

    localparam int unsigned IDX_W = $clog2(ENTRY_NUM);
    localparam int unsigned TAG_W = PC_W - 3 - IDX_W;
    localparam int unsigned TGT_W = PC_W - 2;

    logic             r_valid [ENTRY_NUM];
    logic [TAG_W-1:0] r_tag   [ENTRY_NUM];
    logic             r_slot  [ENTRY_NUM];
    logic [TGT_W-1:0] r_tgt   [ENTRY_NUM];
    logic [1:0]       r_cnt   [ENTRY_NUM];

    // Update path
    logic [IDX_W-1:0] w_upd_idx;
    logic [TAG_W-1:0] w_upd_tag;
    logic             w_upd_slot;
    logic             w_upd_match;
    logic [1:0]       w_cnt_next;
    logic             w_wr_en;
    logic [TGT_W-1:0] w_new_tgt;
    logic [1:0]       w_new_cnt;

    assign w_upd_idx   = i_upd_pc[3+IDX_W-1:3];
    assign w_upd_tag   = i_upd_pc[PC_W-1:3+IDX_W];
    assign w_upd_slot  = i_upd_pc[2];
    assign w_upd_match = r_valid[w_upd_idx] && (r_tag[w_upd_idx] == w_upd_tag)
                         && (r_slot[w_upd_idx] == w_upd_slot);

    btb_predictor_sat_cnt2 u_sat_cnt2 (
        .i_cnt   (r_cnt[w_upd_idx]),
        .i_taken (i_upd_taken),
        .o_cnt   (w_cnt_next)
    );

    // A not-taken miss leaves the table untouched.
    assign w_wr_en   = i_upd_valid && (w_upd_match || i_upd_taken);
    assign w_new_tgt = i_upd_taken ? i_upd_target[PC_W-1:2] : r_tgt[w_upd_idx];
    assign w_new_cnt = w_upd_match ? w_cnt_next : BTB_CNT_ALLOC;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < ENTRY_NUM; i++) begin
                r_valid[i] <= 1'b0;
                r_tag[i]   <= '0;
                r_slot[i]  <= 1'b0;
                r_tgt[i]   <= '0;
                r_cnt[i]   <= BTB_CNT_RESET;
            end
        end else if (w_wr_en) begin
            r_valid[w_upd_idx] <= 1'b1;
            r_tag[w_upd_idx]   <= w_upd_tag;
            r_slot[w_upd_idx]  <= w_upd_slot;
            r_tgt[w_upd_idx]   <= w_new_tgt;
            r_cnt[w_upd_idx]   <= w_new_cnt;
        end
    end

    // Lookup path
    logic [IDX_W-1:0] w_lk_idx;
    logic [TAG_W-1:0] w_lk_tag;
    logic             w_e_valid;
    logic [TAG_W-1:0] w_e_tag;
    logic             w_e_slot;
    logic [TGT_W-1:0] w_e_tgt;
    logic [1:0]       w_e_cnt;
    logic             w_hit;

    assign w_lk_idx = i_pc[3+IDX_W-1:3];
    assign w_lk_tag = i_pc[PC_W-1:3+IDX_W];

    always_comb begin
        w_e_valid = r_valid[w_lk_idx];
        w_e_tag   = r_tag[w_lk_idx];
        w_e_slot  = r_slot[w_lk_idx];
        w_e_tgt   = r_tgt[w_lk_idx];
        w_e_cnt   = r_cnt[w_lk_idx];
`ifdef BTB_UPD_BYPASS_EN
        if (w_wr_en && (w_upd_idx == w_lk_idx)) begin
            w_e_valid = 1'b1;
            w_e_tag   = w_upd_tag;
            w_e_slot  = w_upd_slot;
            w_e_tgt   = w_new_tgt;
            w_e_cnt   = w_new_cnt;
        end
`endif
    end

    // A slot-0 branch is behind the fetch start when fetch begins at slot 1.
    assign w_hit          = w_e_valid && (w_e_tag == w_lk_tag) && (w_e_slot >= i_pc[2]);
    assign o_pred_jmp     = w_hit && w_e_cnt[1];
    assign o_pred_jmpaddr = o_pred_jmp ? {w_e_tgt, 2'b00} : '0;
    assign o_pred_slot    = o_pred_jmp ? w_e_slot : 1'b0;

    logic w_unused_bits;
    assign w_unused_bits = ^{i_pc[1:0], i_upd_pc[1:0], i_upd_target[1:0]};

endmodule

// File: doc/btb_predictor.md
Name: btb_predictor

Overview:
- Two-wide fetch branch predictor: a direct-mapped branch target buffer (BTB) with a 2-bit saturating direction counter per entry.
- Produces the predicted-jump redirect that the PC register consumes: a taken flag plus target for the current 8-byte fetch group.
- Lookup is combinational on the current fetch PC, so the redirect reaches the next-PC mux in the same cycle.
- Trained by the branch-resolution update port on commit/resolve.

Parameters:
- ENTRY_NUM, 16, number of BTB entries; power of two, 4..256.
- IDX_W, $clog2(ENTRY_NUM), index width; derived, not overridden.
- TAG_W, `RV32_PC_WIDTH-3-IDX_W, stored tag width; derived.

Ports:
- clk  in  1  clock.
- rst_n  in  1  reset; asynchronous, active-low.
- i_pc  in  `RV32_PC_WIDTH  current fetch-group PC (PC register output).
- o_pred_jmp  out  1  predict taken redirect for this group.
- o_pred_jmpaddr  out  `RV32_PC_WIDTH  predicted target; bits[1:0] always 0.
- o_pred_slot  out  1  slot of the predicted branch (0 = i_pc&~4, 1 = +4); decode squashes slot 1 when this is 0.
- i_upd_valid  in  1  resolved conditional branch or jump this cycle.
- i_upd_pc  in  `RV32_PC_WIDTH  PC of the resolved instruction.
- i_upd_taken  in  1  actual direction.
- i_upd_target  in  `RV32_PC_WIDTH  actual target.

Behaviour:
- Address fields:
  - idx = pc[3+IDX_W-1:3]
  - tag = pc[`RV32_PC_WIDTH-1:3+IDX_W]
  - slot = pc[2]
- Entry fields: valid, tag, slot, target[31:2], cnt[1:0] (00 SN, 01 WN, 10 WT, 11 ST).
- Lookup (combinational):
  - hit = valid && tag match && entry.slot >= i_pc[2]. A branch in slot 0 is ignored when fetch starts at slot 1.
  - o_pred_jmp = hit && cnt[1].
  - o_pred_jmpaddr = {target,2'b00} when o_pred_jmp, else 0.
  - o_pred_slot = entry.slot when o_pred_jmp, else 0.
- Update (registered on posedge clk when i_upd_valid):
  - Match (valid, tag and slot equal): cnt saturating +1 if taken, -1 if not. Target rewritten only when taken. Saturation at 11 and 00 is held.
  - Miss and taken: allocate by overwriting the indexed entry (valid=1, tag, slot, target, cnt=10). The previous occupant is lost, including a different-slot branch with the same tag.
  - Miss and not taken: no state change.
  - Entries never invalidate once valid; cnt=00 stays resident.
- Update-visible latency: one cycle. A lookup in the cycle after the update edge sees the new state.
- Same-cycle lookup and update to the same index: the lookup returns pre-update state (unless the bypass option below is compiled in).
- Reset (async assert, any time, including mid-update): all valid=0, cnt=01, targets 0. Outputs are then 0 because lookup is combinational on cleared state.
- Stall: no input. The PC register holds i_pc, so lookup is naturally stable. Updates proceed regardless of stall.
- No X on outputs when i_pc is known, even for entries never written.

Optional Feature:
- Macro BTB_UPD_BYPASS_EN.
- When defined: if i_upd_valid and i_upd_pc's idx equals i_pc's idx, the lookup uses the entry value being written this cycle (post-update next-state) instead of the stored one. This is a combinational forward from update to lookup.
- When undefined: lookup returns stored pre-update state, as above.
- Timing cost of the bypass is accepted only when defined.

Decomposition:
- constants.vh gains:
  - BTB_CNT_SN/WN/WT/ST encodings
  - BTB_CNT_RESET (01)
  - BTB_CNT_ALLOC (10)
- `RV32_PC_WIDTH is reused.
- One natural sub-module: sat_cnt2, a combinational 2-bit saturating next-value given cnt and taken. It is instanced once for the update path and reused for the bypass path.

Test Plan:
- Reset, then sweep i_pc=0x0..0x78 step 8 -> o_pred_jmp=0, o_pred_jmpaddr=0 for all.
- Update pc=0x104 taken target=0x200, then i_pc=0x100 -> pred_jmp=1, jmpaddr=0x200, slot=1. i_pc=0x104 -> same hit.
- Update pc=0x100 taken target=0x300, then i_pc=0x104 -> pred_jmp=0 (slot 0 behind fetch start).
- Counter walk on pc=0x108: alloc taken (10), not-taken (01) -> pred 0; taken (10) -> pred 1; taken x3 -> stays 11; not-taken once -> still pred 1.
- Aliasing with ENTRY_NUM=16: allocate pc=0x108, then taken update pc=0x188 target 0x40 -> i_pc=0x108 misses, i_pc=0x188 hits 0x40.
- Same-cycle update alloc and lookup at pc=0x110 -> pred 0 without BTB_UPD_BYPASS_EN, pred 1 with it. Async rst_n pulse mid-cycle -> outputs 0 immediately.
